// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry valid/ready pipeline register with flush bubbles.
// in_ready comes from state alone so the upstream path is fully registered.
module pipe_skid_buffer #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] CLR_MASK = {WIDTH{1'b1}},
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] or_q, or_d, sr_q, sr_d;
    logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;
    logic             accept, consume;

    assign in_ready   = state_q != TWO;
    assign out_valid  = state_q != EMPTY;
    assign out_data   = or_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        or_d     = or_q;
        sr_d     = sr_q;
        bubble_d = bubble_q;
        stall_d  = (out_valid && !out_ready && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
        if (flush) begin
            // a flush with an accept loads a masked bubble instead of the word
            sr_d    = '0;
            or_d    = accept ? (in_data & ~CLR_MASK) : '0;
            state_d = accept ? ONE : EMPTY;
            bubble_d = (accept && bubble_q != '1) ? bubble_q + CNT_W'(1) : bubble_q;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        or_d    = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        or_d = in_data;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        sr_d    = in_data;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    if (consume) begin
                        or_d    = sr_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            or_q     <= '0;
            sr_q     <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            or_q     <= or_d;
            sr_q     <= sr_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end
endmodule
